// File: rtl/octal_display_scan_pkg.sv
// Shared widths, FSM state type and digit-select helper for the octal display scanner.
package octal_disp_pkg;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned SEG_W      = 7;

  typedef enum logic {
    S_GAP,
    S_ON
  } state_t;

  function automatic logic [NUM_DIGITS-1:0] digit_sel(input logic [1:0] idx);
    logic [NUM_DIGITS-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 2'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/octal_display_scan_timer.sv
// Shared slot/gap timer: up-counter from zero, cleared on every state change.
module scan_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] lim,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= cnt + W'(1);
  end

  assign tc = (cnt == lim);

endmodule

// File: rtl/octal_display_scan.sv
// Time-multiplexes three 7-segment patterns onto a shared segment bus with
// per-frame snapshotting and an optional dead-time gap between digits.
module octal_display_scan
  import octal_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned DIG_ACTIVE_LOW = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NUM_DIGITS-1:0] A,
  input  logic [NUM_DIGITS-1:0] B,
  input  logic [NUM_DIGITS-1:0] C,
  input  logic [NUM_DIGITS-1:0] D,
  input  logic [NUM_DIGITS-1:0] E,
  input  logic [NUM_DIGITS-1:0] F,
  input  logic [NUM_DIGITS-1:0] G,
  input  logic                  EN,
  input  logic [NUM_DIGITS-1:0] DIG_BLANK,
  output logic [SEG_W-1:0]      SEG,
  output logic [NUM_DIGITS-1:0] AN,
  output logic                  FRAME_STB
);

  localparam int unsigned CW = $clog2(SCAN_DIV + BLANK_CYCLES + 1);
  localparam logic [CW-1:0] ON_LIM  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GAP_LIM = (BLANK_CYCLES == 0) ? '0 : CW'(BLANK_CYCLES - 1);
  localparam logic [SEG_W-1:0]      SEG_INV = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

  state_t                        state, state_nxt;
  logic [1:0]                    idx, idx_nxt;
  logic [NUM_DIGITS*SEG_W-1:0]   snap, snap_nxt;
  logic                          clr, load_snap, tc, gap_done;
  logic [CW-1:0]                 lim;
  logic [SEG_W-1:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]         an_nxt;

  assign lim      = (state == S_ON) ? ON_LIM : GAP_LIM;
  assign gap_done = (BLANK_CYCLES == 0) || tc;

  scan_timer #(.W(CW)) u_timer (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (clr),
    .lim   (lim),
    .tc    (tc)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr       = 1'b0;
    load_snap = 1'b0;
    unique case (state)
      S_GAP: begin
        if (gap_done) begin
          state_nxt = S_ON;
          clr       = 1'b1;
          load_snap = (idx == 2'd0);
        end
      end
      S_ON: begin
        if (tc) begin
          idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
          clr     = 1'b1;
          // With no gap the frame boundary is crossed directly from S_ON.
          if (BLANK_CYCLES == 0) begin
            state_nxt = S_ON;
            load_snap = (idx_nxt == 2'd0);
          end else begin
            state_nxt = S_GAP;
          end
        end
      end
      default: state_nxt = S_GAP;
    endcase
  end

  // Outputs are decoded from next-state values so the registered bus matches the registered state.
  always_comb begin
    snap_nxt = snap;
    seg_nxt  = '0;
    an_nxt   = '0;
    if (load_snap) begin
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
        snap_nxt[d*SEG_W +: SEG_W] = {G[d], F[d], E[d], D[d], C[d], B[d], A[d]};
      end
    end
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (state_nxt == S_ON && EN && idx_nxt == 2'(d) && !DIG_BLANK[d]) begin
        seg_nxt = snap_nxt[d*SEG_W +: SEG_W];
        an_nxt  = digit_sel(idx_nxt);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= S_GAP;
      idx       <= '0;
      snap      <= '0;
      SEG       <= SEG_INV;
      AN        <= DIG_INV;
      FRAME_STB <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      snap      <= snap_nxt;
      SEG       <= seg_nxt ^ SEG_INV;
      AN        <= an_nxt ^ DIG_INV;
      FRAME_STB <= load_snap;
    end
  end

endmodule
